mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between instruction fetch (IF) and
// data memory (DM) requesters. One transaction is in flight at a time.
// Data and fetch requests are arbitrated with a fairness rule so fetch never
// loses twice in a row. A stalled memory leads to a sticky error state that
// only reset clears. All outputs are registered.
module mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int CW = (MAX_WAIT <= 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   wait_cnt_r, wait_cnt_s;
  logic            owner_dm_r, owner_dm_s;   // 1 = data owns the transaction
  logic            if_owed_r, if_owed_s;     // last grant was DM while IF waited
  logic            grant_dm_s;
  logic            capture_s;                // memory data valid on this edge
  logic            wr_s;
  logic [15:0]     addr_s, wdata_s;

  // Next-state, grant selection and transaction latch values.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    owner_dm_s = owner_dm_r;
    if_owed_s  = if_owed_r;
    grant_dm_s = 1'b0;
    capture_s  = 1'b0;
    wr_s       = mem_wr;
    addr_s     = mem_addr;
    wdata_s    = mem_wdata;
    case (state_r)
      ST_IDLE: begin
        if (!halt && (if_req || dm_req)) begin
          if (if_req && dm_req) begin
            grant_dm_s = ~if_owed_r;
          end else begin
            grant_dm_s = dm_req;
          end
          state_s    = ST_ISSUE;
          wait_cnt_s = {CW{1'b0}};
          owner_dm_s = grant_dm_s;
          if (grant_dm_s) begin
            wr_s      = dm_wr;
            addr_s    = dm_addr;
            wdata_s   = dm_wdata;
            if_owed_s = if_req;
          end else begin
            wr_s      = 1'b0;
            addr_s    = if_addr;
            wdata_s   = 16'h0000;
            if_owed_s = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_done) begin
          capture_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s    = ST_WAIT;
          wait_cnt_s = {CW{1'b0}};
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          capture_s = 1'b1;
          state_s   = ST_DONE;
        end else if (wait_cnt_r == CW'(MAX_WAIT - 1)) begin
          state_s = ST_ERR;
        end else begin
          wait_cnt_s = wait_cnt_r + CW'(32'd1);
          state_s    = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_ERR: begin
        state_s = ST_ERR;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, history and registered outputs; synchronous reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {CW{1'b0}};
      owner_dm_r <= 1'b0;
      if_owed_r  <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= 16'h0000;
      dm_rdata   <= 16'h0000;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      owner_dm_r <= owner_dm_s;
      if_owed_r  <= if_owed_s;
      mem_en     <= (state_s == ST_ISSUE);
      mem_wr     <= wr_s;
      mem_addr   <= addr_s;
      mem_wdata  <= wdata_s;
      if_done    <= (state_s == ST_DONE) && !owner_dm_s;
      dm_done    <= (state_s == ST_DONE) && owner_dm_s;
      err        <= (state_s == ST_ERR);
      if (capture_s && !owner_dm_r) begin
        if_rdata <= mem_rdata;
      end
      if (capture_s && owner_dm_r && !mem_wr) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against mem_arbiter with a transaction-level
// reference model (busy/age/owed bookkeeping) compared on every cycle, plus
// hand-computed literal expectations for latency, ordering and error timing.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst, halt, if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        mem_done, mem_en, mem_wr, if_done, dm_done, err;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  // memory responder
  logic resp_done  = 1'b0;
  logic extra_done = 1'b0;
  int   lat   = -1;
  int   rcnt  = 0;
  bit   rbusy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_on   = 1'b0;

  // reference model
  bit          m_busy, m_cool, m_err, m_owed, m_own_dm, m_wr;
  int          m_age;
  logic [15:0] m_addr, m_wdata;
  logic        e_mem_en, e_if_done, e_dm_done, e_err;
  logic [15:0] e_if_rdata, e_dm_rdata;

  assign mem_done = resp_done | extra_done;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: one transaction at a time; a completed transaction costs one
  // extra cycle before the next grant; age counts cycles since issue.
  task automatic model_step();
    bit pick_dm;
    if (rst) begin
      m_busy = 0; m_cool = 0; m_err = 0; m_owed = 0; m_own_dm = 0; m_wr = 0;
      m_age = 0; m_addr = 16'h0000; m_wdata = 16'h0000;
      e_mem_en = 0; e_if_done = 0; e_dm_done = 0; e_err = 0;
      e_if_rdata = 16'h0000; e_dm_rdata = 16'h0000;
      return;
    end
    e_mem_en = 0; e_if_done = 0; e_dm_done = 0;
    if (m_err) begin
      // stuck until reset
    end else if (m_busy) begin
      if (mem_done) begin
        m_busy = 0;
        m_cool = 1;
        if (m_own_dm) begin
          e_dm_done = 1;
          if (!m_wr) e_dm_rdata = mem_rdata;
        end else begin
          e_if_done = 1;
          e_if_rdata = mem_rdata;
        end
      end else if (m_age == MAX_WAIT) begin
        m_busy = 0;
        m_err  = 1;
      end else begin
        m_age++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (!halt && (if_req || dm_req)) begin
      pick_dm  = dm_req && !(if_req && m_owed);
      m_owed   = pick_dm && if_req;
      m_own_dm = pick_dm;
      m_wr     = pick_dm ? dm_wr : 1'b0;
      m_addr   = pick_dm ? dm_addr : if_addr;
      m_wdata  = dm_wdata;
      m_busy   = 1;
      m_age    = 0;
      e_mem_en = 1;
    end
    e_err = m_err;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("mem_en",   16'(mem_en),  16'(e_mem_en));
      chk("if_done",  16'(if_done), 16'(e_if_done));
      chk("dm_done",  16'(dm_done), 16'(e_dm_done));
      chk("err",      16'(err),     16'(e_err));
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_rdata", dm_rdata, e_dm_rdata);
      if (m_busy || m_cool) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wr", 16'(mem_wr), 16'(m_wr));
        if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // memory responder: completes lat cycles after the issue cycle (-1 = never)
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      rcnt  = 0;
      rbusy = 1'b1;
    end else if (rbusy) begin
      rcnt++;
    end
    if (rbusy && rcnt == lat) begin
      resp_done = 1'b1;
      rbusy     = 1'b0;
    end else begin
      resp_done = 1'b0;
    end
  end

  // which: 0 = mem_en, 1 = if_done, 2 = dm_done
  task automatic wait_sig(input int which, input int max, input string name, output int took);
    took = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if ((which == 0 && mem_en) || (which == 1 && if_done) || (which == 2 && dm_done)) begin
        took = k;
        break;
      end
    end
    if (took < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no event in %0d cycles, required one", name, max);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"},    16'(mem_en),  16'h0000);
    chk({tag, "_if_done"},   16'(if_done), 16'h0000);
    chk({tag, "_dm_done"},   16'(dm_done), 16'h0000);
    chk({tag, "_err"},       16'(err),     16'h0000);
    chk({tag, "_mem_wr"},    16'(mem_wr),  16'h0000);
    chk({tag, "_mem_addr"},  mem_addr,  16'h0000);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
    chk({tag, "_if_rdata"},  if_rdata,  16'h0000);
    chk({tag, "_dm_rdata"},  dm_rdata,  16'h0000);
  endtask

  // zero-wait fetch: issue one cycle after the sampling edge, done one later
  task automatic t_fetch(input logic [15:0] a, input logic [15:0] d, input string tag);
    lat = 0; mem_rdata = d; if_addr = a;
    @(negedge clk);
    if_req = 1'b1;
    @(negedge clk);
    chk({tag, "_mem_en_c1"}, 16'(mem_en), 16'h0001);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_wr"}, 16'(mem_wr), 16'h0000);
    @(negedge clk);
    chk({tag, "_if_done_c2"}, 16'(if_done), 16'h0001);
    chk({tag, "_if_rdata"}, if_rdata, d);
    chk({tag, "_model_rdata"}, e_if_rdata, d);
    if_req = 1'b0;
    @(negedge clk);
    chk({tag, "_if_done_once"}, 16'(if_done), 16'h0000);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int          took, nd, at, nmem;
    logic [15:0] la[$];
    logic        lw[$];
    logic [15:0] lwd[$];
    logic [15:0] exp_a [4];
    logic        exp_w [4];

    rst = 1'b1; halt = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = 16'h0000; dm_addr = 16'h0000; dm_wdata = 16'h0000; mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;
    chk_all_zero("reset");
    idle(2);

    // zero-wait fetch
    t_fetch(16'h0010, 16'hB3C0, "t1");
    idle(2);

    // both held: DM store and IF alternate
    lat = 0; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234; if_addr = 16'h0040;
    mem_rdata = 16'h4444;
    @(negedge clk);
    if_req = 1'b1; dm_req = 1'b1;
    nd = 0;
    for (int k = 0; k < 80 && nd < 4; k++) begin
      @(negedge clk);
      if (mem_en) begin
        la.push_back(mem_addr);
        lw.push_back(mem_wr);
        lwd.push_back(mem_wdata);
      end
      if (if_done || dm_done) nd++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    exp_a = '{16'h0200, 16'h0040, 16'h0200, 16'h0040};
    exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    chk("t2_grants", 16'(la.size()), 16'h0004);
    for (int i = 0; i < la.size() && i < 4; i++) begin
      chk("t2_order_addr", la[i], exp_a[i]);
      chk("t2_order_wr", 16'(lw[i]), 16'(exp_w[i]));
      if (exp_w[i]) chk("t2_wdata", lwd[i], 16'h1234);
    end
    idle(3);

    // DM load with five-cycle memory latency
    lat = 5; dm_wr = 1'b0; dm_addr = 16'h0200; mem_rdata = 16'hFFFF;
    @(negedge clk);
    dm_req = 1'b1;
    wait_sig(0, 10, "t3_issue", took);
    chk("t3_addr_issue", mem_addr, 16'h0200);
    nd = 0; at = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 6) chk("t3_addr_stable", mem_addr, 16'h0200);
      if (dm_done) begin
        nd++;
        at = k;
        dm_req = 1'b0;
      end
    end
    chk("t3_done_count", 16'(nd), 16'h0001);
    chk("t3_done_latency", 16'(at), 16'h0006);
    chk("t3_dm_rdata", dm_rdata, 16'hFFFF);
    idle(2);

    // halt raised during WAIT with fetch pending
    lat = 4; dm_wr = 1'b0; dm_addr = 16'h0300; if_addr = 16'h0080; mem_rdata = 16'h5A5A;
    @(negedge clk);
    dm_req = 1'b1;
    wait_sig(0, 10, "t4_issue", took);
    @(negedge clk);
    halt = 1'b1; if_req = 1'b1;
    wait_sig(2, 10, "t4_dm_done", took);
    dm_req = 1'b0;
    chk("t4_dm_rdata", dm_rdata, 16'h5A5A);
    nmem = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_en) nmem++;
    end
    chk("t4_no_issue_halted", 16'(nmem), 16'h0000);
    halt = 1'b0;
    wait_sig(1, 12, "t4_if_done", took);
    if_req = 1'b0;
    chk("t4_if_rdata", if_rdata, 16'h5A5A);
    idle(2);

    // reset in WAIT, late mem_done afterwards
    lat = -1; dm_wr = 1'b0; dm_addr = 16'h0300; mem_rdata = 16'hDEAD;
    @(negedge clk);
    dm_req = 1'b1;
    wait_sig(0, 10, "t5_issue", took);
    idle(2);
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; extra_done = 1'b1;
    chk_all_zero("t5_after_rst");
    @(negedge clk);
    extra_done = 1'b0;
    chk_all_zero("t5_late_done");
    idle(2);

    // timeout: memory never answers
    lat = -1; dm_wr = 1'b1; dm_addr = 16'h0400; dm_wdata = 16'h0BAD;
    @(negedge clk);
    dm_req = 1'b1;
    wait_sig(0, 10, "t6_issue", took);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 15) chk("t6_err_wait15", 16'(err), 16'h0000);
    end
    @(negedge clk);
    chk("t6_err_set", 16'(err), 16'h0001);
    chk("t6_model_err", 16'(e_err), 16'h0001);
    lat = 0; if_req = 1'b1;
    nmem = 0; nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_en) nmem++;
      if (if_done || dm_done) nd++;
    end
    chk("t6_no_issue_in_err", 16'(nmem), 16'h0000);
    chk("t6_no_done_in_err", 16'(nd), 16'h0000);
    chk("t6_err_sticky", 16'(err), 16'h0001);
    if_req = 1'b0; dm_req = 1'b0;
    pulse_reset();
    chk_all_zero("t6_rst");
    idle(1);

    // recovery after reset
    t_fetch(16'h0123, 16'h7E01, "t7");
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
